// File: rtl/ledmtx_sched_if.sv
// Signal bundle between the frame scheduler, its request sources and the ledmtx driver.
// The scheduler takes the master modport; the board top or the testbench takes the slave modport.
interface ledmtx_sched_if #(
  parameter int OFFSET_W = 16,
  parameter int IDX_W    = 3
);
  logic                auto_en;
  logic                next_req;
  logic                prev_req;
  logic                refresh_req;
  logic                drv_busy;
  logic                drv_start;
  logic [OFFSET_W-1:0] drv_ram_offset;
  logic [IDX_W-1:0]    img_idx;
  logic                pending;

  modport master (
    input  auto_en, next_req, prev_req, refresh_req, drv_busy,
    output drv_start, drv_ram_offset, img_idx, pending
  );

  modport slave (
    output auto_en, next_req, prev_req, refresh_req, drv_busy,
    input  drv_start, drv_ram_offset, img_idx, pending
  );
endinterface

// File: rtl/ledmtx_sched.sv
// Frame scheduler for the MAX7219 matrix driver: arbitrates auto/manual/refresh requests
// and issues start + image base offset only while the driver is idle.
//
// state       | meaning
// S_IDLE      | arbitrate pending flags when the driver is not busy
// S_ISSUE     | drv_start high for this single cycle
// S_WAIT_BUSY | wait for drv_busy to rise, give up after BUSY_TO cycles
// S_WAIT_DONE | wait for drv_busy to fall
module ledmtx_sched #(
  parameter int NUM_IMAGES = 7,
  parameter int IMG_STRIDE = 13,
  parameter int DWELL_MAX  = 199_999_999,
  parameter int OFFSET_W   = 16,
  parameter int BUSY_TO    = 4
) (
  input  logic           clk,
  input  logic           rst,
  ledmtx_sched_if.master bus
);
  localparam int IDX_W = $clog2(NUM_IMAGES);
  localparam int DW_W  = (DWELL_MAX > 0) ? $clog2(DWELL_MAX + 1) : 1;
  localparam int TO_W  = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;

  localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(NUM_IMAGES - 1);
  localparam logic [OFFSET_W-1:0] OFF_STRIDE = OFFSET_W'(IMG_STRIDE);
  localparam logic [OFFSET_W-1:0] OFF_LAST   = OFFSET_W'((NUM_IMAGES - 1) * IMG_STRIDE);
  localparam logic [DW_W-1:0]     DWELL_TC   = DW_W'(DWELL_MAX);
  localparam logic [TO_W-1:0]     TO_LOAD    = TO_W'(BUSY_TO - 1);

  if (NUM_IMAGES < 2) begin : g_chk_num
    $error("ledmtx_sched: NUM_IMAGES must be at least 2");
  end
  if ((longint'(NUM_IMAGES - 1) * IMG_STRIDE) >= (longint'(1) << OFFSET_W)) begin : g_chk_off
    $error("ledmtx_sched: last image offset does not fit in OFFSET_W bits");
  end
  if (BUSY_TO < 1) begin : g_chk_to
    $error("ledmtx_sched: BUSY_TO must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE} state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    idx;
  logic [OFFSET_W-1:0] offset;
  logic [DW_W-1:0]     dwell;
  logic [TO_W-1:0]     to_cnt;
  logic                pend_next, pend_prev, pend_auto, pend_refresh;
  logic                step_fwd, step_back, manual_step;
  logic                clr_next, clr_prev, clr_auto, clr_refresh;
  logic                dwell_hit;

  assign dwell_hit = bus.auto_en && (dwell == DWELL_TC);

  always_comb begin
    state_nxt   = state;
    step_fwd    = 1'b0;
    step_back   = 1'b0;
    manual_step = 1'b0;
    clr_next    = 1'b0;
    clr_prev    = 1'b0;
    clr_auto    = 1'b0;
    clr_refresh = 1'b0;
    case (state)
      S_IDLE: begin
        if (!bus.drv_busy && (pend_next || pend_prev || pend_auto || pend_refresh)) begin
          state_nxt   = S_ISSUE;
          clr_refresh = 1'b1;
          // Opposing buttons cancel out; the current frame is simply resent.
          if (pend_next && pend_prev) begin
            clr_next = 1'b1;
            clr_prev = 1'b1;
          end else if (pend_next) begin
            step_fwd    = 1'b1;
            manual_step = 1'b1;
            clr_next    = 1'b1;
            clr_auto    = 1'b1;
          end else if (pend_prev) begin
            step_back   = 1'b1;
            manual_step = 1'b1;
            clr_prev    = 1'b1;
            clr_auto    = 1'b1;
          end else if (pend_auto) begin
            step_fwd = 1'b1;
            clr_auto = 1'b1;
          end
        end
      end
      S_ISSUE:     state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (bus.drv_busy)        state_nxt = S_WAIT_DONE;
        else if (to_cnt == '0)   state_nxt = S_IDLE;
      end
      S_WAIT_DONE: if (!bus.drv_busy) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      idx          <= '0;
      offset       <= '0;
      dwell        <= '0;
      to_cnt       <= '0;
      pend_next    <= 1'b0;
      pend_prev    <= 1'b0;
      pend_auto    <= 1'b0;
      pend_refresh <= 1'b1;
    end else begin
      state <= state_nxt;

      if (step_fwd) begin
        if (idx == IDX_LAST) begin
          idx    <= '0;
          offset <= '0;
        end else begin
          idx    <= idx + IDX_W'(1);
          offset <= offset + OFF_STRIDE;
        end
      end else if (step_back) begin
        if (idx == '0) begin
          idx    <= IDX_LAST;
          offset <= OFF_LAST;
        end else begin
          idx    <= idx - IDX_W'(1);
          offset <= offset - OFF_STRIDE;
        end
      end

      if (state == S_ISSUE)
        to_cnt <= TO_LOAD;
      else if (state == S_WAIT_BUSY && to_cnt != '0)
        to_cnt <= to_cnt - TO_W'(1);

      if (!bus.auto_en || manual_step || dwell == DWELL_TC)
        dwell <= '0;
      else
        dwell <= dwell + DW_W'(1);

      // A request landing on the same edge as its clear survives.
      pend_next    <= bus.next_req    | (pend_next    & ~clr_next);
      pend_prev    <= bus.prev_req    | (pend_prev    & ~clr_prev);
      pend_auto    <= dwell_hit       | (pend_auto    & ~clr_auto);
      pend_refresh <= bus.refresh_req | (pend_refresh & ~clr_refresh);
    end
  end

  assign bus.drv_start      = (state == S_ISSUE);
  assign bus.drv_ram_offset = offset;
  assign bus.img_idx        = idx;
  assign bus.pending        = pend_next | pend_prev | pend_auto | pend_refresh;
endmodule

// File: tb/tb_ledmtx_sched.sv
// Randomized self-checking bench for ledmtx_sched with a behavioural driver model
// and an index/offset reference computed directly from the image arithmetic.
`timescale 1ns/1ps
module tb_ledmtx_sched;
  localparam int NUM_IMAGES = 7;
  localparam int IMG_STRIDE = 13;
  localparam int DWELL_MAX  = 99;
  localparam int OFFSET_W   = 16;
  localparam int BUSY_TO    = 4;
  localparam int IDX_W      = $clog2(NUM_IMAGES);

  logic clk = 1'b0;
  logic rst = 1'b0;

  ledmtx_sched_if #(.OFFSET_W(OFFSET_W), .IDX_W(IDX_W)) bus ();

  ledmtx_sched #(
    .NUM_IMAGES(NUM_IMAGES), .IMG_STRIDE(IMG_STRIDE), .DWELL_MAX(DWELL_MAX),
    .OFFSET_W(OFFSET_W), .BUSY_TO(BUSY_TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int m_idx    = 0;

  always @(posedge clk) cyc++;

  // Driver model: busy rises the cycle after start and stays high busy_len cycles.
  int busy_len  = 20;
  bit busy_mode = 1'b1;
  int busy_left = 0;
  always @(negedge clk) begin
    if (!rst) begin
      busy_left    = 0;
      bus.drv_busy = 1'b0;
    end else begin
      bus.drv_busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      if (bus.drv_start === 1'b1 && busy_mode) busy_left = busy_len;
    end
  end

  int start_cnt = 0;
  int start_cyc = 0;
  int start_idx = 0;
  int start_off = 0;
  always @(negedge clk) begin
    if (bus.drv_start === 1'b1) begin
      start_cnt++;
      start_cyc = cyc;
      start_idx = int'(bus.img_idx);
      start_off = int'(bus.drv_ram_offset);
    end
  end

  function automatic int exp_off(input int i);
    return i * IMG_STRIDE;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input bit n, input bit p, input bit r, output int pc);
    bus.next_req    = n;
    bus.prev_req    = p;
    bus.refresh_req = r;
    pc = cyc;
    tick();
    bus.next_req    = 1'b0;
    bus.prev_req    = 1'b0;
    bus.refresh_req = 1'b0;
  endtask

  task automatic wait_start(input int c0, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (start_cnt > c0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL start_timeout got=no_start expected=start within %0d cycles", budget);
    end
  endtask

  task automatic wait_idle();
    int quiet = 0;
    for (int i = 0; i < 600 && quiet < 8; i++) begin
      tick();
      if (bus.drv_busy === 1'b0 && bus.pending === 1'b0 && bus.drv_start === 1'b0) quiet++;
      else quiet = 0;
    end
    checks++;
    if (quiet < 8) begin
      failures++;
      $display("FAIL idle_timeout got=not_idle expected=idle");
    end
  endtask

  task automatic test_reset();
    int  r;
    int  c0;
    bit  ok;
    rst = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks += 4;
    if (bus.drv_start !== 1'b0) begin failures++; $display("FAIL rst_start got=%0b expected=0", bus.drv_start); end
    if (bus.img_idx !== '0) begin failures++; $display("FAIL rst_idx got=%0d expected=0", bus.img_idx); end
    if (bus.drv_ram_offset !== '0) begin failures++; $display("FAIL rst_off got=%0d expected=0", bus.drv_ram_offset); end
    if (bus.pending !== 1'b1) begin failures++; $display("FAIL rst_pending got=%0b expected=1", bus.pending); end
    @(posedge clk);
    #1;
    c0  = start_cnt;
    rst = 1'b1;
    r   = cyc;
    m_idx = 0;
    wait_start(c0, 10, ok);
    if (ok) begin
      checks += 4;
      if (start_cyc - r !== 1) begin failures++; $display("FAIL rst_latency got=%0d expected=1", start_cyc - r); end
      if (start_idx !== 0) begin failures++; $display("FAIL rst_first_idx got=%0d expected=0", start_idx); end
      if (start_off !== 0) begin failures++; $display("FAIL rst_first_off got=%0d expected=0", start_off); end
      if (bus.pending !== 1'b0) begin failures++; $display("FAIL rst_pending_after got=%0b expected=0", bus.pending); end
    end
  endtask

  task automatic test_auto();
    int e;
    int prev_s;
    int c0;
    bit ok;
    wait_idle();
    bus.auto_en = 1'b1;
    e = cyc;
    prev_s = 0;
    for (int k = 1; k <= NUM_IMAGES; k++) begin
      c0 = start_cnt;
      wait_start(c0, 3 * (DWELL_MAX + 1), ok);
      if (!ok) break;
      m_idx = (m_idx + 1) % NUM_IMAGES;
      checks += 3;
      if (start_idx !== m_idx) begin failures++; $display("FAIL auto_idx[%0d] got=%0d expected=%0d", k, start_idx, m_idx); end
      if (start_off !== exp_off(m_idx)) begin failures++; $display("FAIL auto_off[%0d] got=%0d expected=%0d", k, start_off, exp_off(m_idx)); end
      if (k == 1) begin
        if (start_cyc - e !== DWELL_MAX + 2) begin failures++; $display("FAIL auto_first_gap got=%0d expected=%0d", start_cyc - e, DWELL_MAX + 2); end
      end else begin
        if (start_cyc - prev_s !== DWELL_MAX + 1) begin failures++; $display("FAIL auto_gap[%0d] got=%0d expected=%0d", k, start_cyc - prev_s, DWELL_MAX + 1); end
      end
      prev_s = start_cyc;
    end
    bus.auto_en = 1'b0;
  endtask

  task automatic test_prev_next();
    int pc;
    int c0;
    bit ok;
    wait_idle();
    c0 = start_cnt;
    send_req(1'b0, 1'b1, 1'b0, pc);
    wait_start(c0, 50, ok);
    m_idx = (m_idx + NUM_IMAGES - 1) % NUM_IMAGES;
    if (ok) begin
      checks += 3;
      if (start_idx !== m_idx) begin failures++; $display("FAIL prev_idx got=%0d expected=%0d", start_idx, m_idx); end
      if (start_off !== exp_off(m_idx)) begin failures++; $display("FAIL prev_off got=%0d expected=%0d", start_off, exp_off(m_idx)); end
      if (start_cyc - pc !== 2) begin failures++; $display("FAIL prev_latency got=%0d expected=2", start_cyc - pc); end
    end
    wait_idle();
    c0 = start_cnt;
    send_req(1'b1, 1'b0, 1'b0, pc);
    wait_start(c0, 50, ok);
    m_idx = (m_idx + 1) % NUM_IMAGES;
    if (ok) begin
      checks += 3;
      if (start_idx !== m_idx) begin failures++; $display("FAIL next_idx got=%0d expected=%0d", start_idx, m_idx); end
      if (start_off !== exp_off(m_idx)) begin failures++; $display("FAIL next_off got=%0d expected=%0d", start_off, exp_off(m_idx)); end
      if (start_cyc - pc !== 2) begin failures++; $display("FAIL next_latency got=%0d expected=2", start_cyc - pc); end
    end
  endtask

  task automatic test_conflict();
    int pc;
    int c0;
    bit ok;
    while (m_idx != 3) begin
      wait_idle();
      c0 = start_cnt;
      send_req(1'b1, 1'b0, 1'b0, pc);
      wait_start(c0, 50, ok);
      m_idx = (m_idx + 1) % NUM_IMAGES;
    end
    wait_idle();
    c0 = start_cnt;
    send_req(1'b1, 1'b1, 1'b0, pc);
    wait_start(c0, 50, ok);
    if (ok) begin
      checks += 2;
      if (start_idx !== m_idx) begin failures++; $display("FAIL both_idx got=%0d expected=%0d", start_idx, m_idx); end
      if (start_off !== exp_off(m_idx)) begin failures++; $display("FAIL both_off got=%0d expected=%0d", start_off, exp_off(m_idx)); end
    end
    repeat (60) tick();
    checks++;
    if (start_cnt !== c0 + 1) begin failures++; $display("FAIL both_count got=%0d expected=%0d", start_cnt - c0, 1); end
  endtask

  task automatic test_back_to_back();
    int pc;
    int c0;
    int ms;
    bit ok;
    wait_idle();
    busy_len    = 20;
    bus.auto_en = 1'b1;
    c0 = start_cnt;
    send_req(1'b0, 1'b0, 1'b1, pc);
    wait_start(c0, 50, ok);
    checks++;
    if (start_idx !== m_idx) begin failures++; $display("FAIL refresh_idx got=%0d expected=%0d", start_idx, m_idx); end
    c0 = start_cnt;
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      send_req(1'b1, 1'b0, 1'b0, pc);
      tick();
    end
    checks += 2;
    if (bus.drv_busy !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%0b expected=1", bus.drv_busy); end
    if (bus.pending !== 1'b1) begin failures++; $display("FAIL b2b_pending got=%0b expected=1", bus.pending); end
    wait_start(c0, 80, ok);
    m_idx = (m_idx + 1) % NUM_IMAGES;
    ms = start_cyc;
    if (ok) begin
      checks += 3;
      if (start_cnt !== c0 + 1) begin failures++; $display("FAIL b2b_count got=%0d expected=1", start_cnt - c0); end
      if (start_idx !== m_idx) begin failures++; $display("FAIL b2b_idx got=%0d expected=%0d", start_idx, m_idx); end
      if (start_off !== exp_off(m_idx)) begin failures++; $display("FAIL b2b_off got=%0d expected=%0d", start_off, exp_off(m_idx)); end
    end
    c0 = start_cnt;
    wait_start(c0, 3 * (DWELL_MAX + 1), ok);
    m_idx = (m_idx + 1) % NUM_IMAGES;
    if (ok) begin
      checks += 2;
      if (start_cyc - ms !== DWELL_MAX + 2) begin failures++; $display("FAIL dwell_restart_gap got=%0d expected=%0d", start_cyc - ms, DWELL_MAX + 2); end
      if (start_idx !== m_idx) begin failures++; $display("FAIL dwell_restart_idx got=%0d expected=%0d", start_idx, m_idx); end
    end
    bus.auto_en = 1'b0;
  endtask

  task automatic test_no_busy();
    int pc;
    int c0;
    int s1;
    bit ok;
    wait_idle();
    busy_mode = 1'b0;
    c0 = start_cnt;
    send_req(1'b1, 1'b0, 1'b0, pc);
    wait_start(c0, 50, ok);
    m_idx = (m_idx + 1) % NUM_IMAGES;
    s1 = start_cyc;
    checks++;
    if (start_idx !== m_idx) begin failures++; $display("FAIL nobusy_idx1 got=%0d expected=%0d", start_idx, m_idx); end
    c0 = start_cnt;
    send_req(1'b1, 1'b0, 1'b0, pc);
    wait_start(c0, 50, ok);
    m_idx = (m_idx + 1) % NUM_IMAGES;
    if (ok) begin
      checks += 3;
      if (start_cyc - s1 !== BUSY_TO + 2) begin failures++; $display("FAIL nobusy_gap got=%0d expected=%0d", start_cyc - s1, BUSY_TO + 2); end
      if (start_idx !== m_idx) begin failures++; $display("FAIL nobusy_idx2 got=%0d expected=%0d", start_idx, m_idx); end
      if (start_off !== exp_off(m_idx)) begin failures++; $display("FAIL nobusy_off2 got=%0d expected=%0d", start_off, exp_off(m_idx)); end
    end
    repeat (BUSY_TO + 2) tick();
    busy_mode = 1'b1;
  endtask

  task automatic test_rst_mid_frame();
    int pc;
    int c0;
    int r;
    bit ok;
    wait_idle();
    busy_len = 20;
    if (m_idx == 0) begin
      c0 = start_cnt;
      send_req(1'b1, 1'b0, 1'b0, pc);
      wait_start(c0, 50, ok);
      m_idx = 1;
      wait_idle();
    end
    c0 = start_cnt;
    send_req(1'b0, 1'b0, 1'b1, pc);
    wait_start(c0, 50, ok);
    repeat (5) tick();
    checks++;
    if (bus.drv_busy !== 1'b1) begin failures++; $display("FAIL midrst_busy got=%0b expected=1", bus.drv_busy); end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks += 4;
    if (bus.drv_start !== 1'b0) begin failures++; $display("FAIL midrst_start got=%0b expected=0", bus.drv_start); end
    if (bus.img_idx !== '0) begin failures++; $display("FAIL midrst_idx got=%0d expected=0", bus.img_idx); end
    if (bus.drv_ram_offset !== '0) begin failures++; $display("FAIL midrst_off got=%0d expected=0", bus.drv_ram_offset); end
    if (bus.pending !== 1'b1) begin failures++; $display("FAIL midrst_pending got=%0b expected=1", bus.pending); end
    @(posedge clk);
    #1;
    c0  = start_cnt;
    rst = 1'b1;
    r   = cyc;
    m_idx = 0;
    wait_start(c0, 10, ok);
    if (ok) begin
      checks += 2;
      if (start_cyc - r !== 1) begin failures++; $display("FAIL midrst_latency got=%0d expected=1", start_cyc - r); end
      if (start_idx !== 0) begin failures++; $display("FAIL midrst_first_idx got=%0d expected=0", start_idx); end
    end
  endtask

  task automatic test_random();
    int pc;
    int c0;
    int op;
    bit ok;
    for (int it = 0; it < 16; it++) begin
      wait_idle();
      op       = int'($urandom_range(0, 3));
      busy_len = int'($urandom_range(1, 30));
      repeat ($urandom_range(0, 5)) tick();
      c0 = start_cnt;
      case (op)
        0: send_req(1'b1, 1'b0, 1'b0, pc);
        1: send_req(1'b0, 1'b1, 1'b0, pc);
        2: send_req(1'b0, 1'b0, 1'b1, pc);
        default: send_req(1'b1, 1'b1, 1'b0, pc);
      endcase
      if (op == 0) m_idx = (m_idx + 1) % NUM_IMAGES;
      if (op == 1) m_idx = (m_idx + NUM_IMAGES - 1) % NUM_IMAGES;
      wait_start(c0, 60, ok);
      if (ok) begin
        checks += 3;
        if (start_idx !== m_idx) begin failures++; $display("FAIL rand_idx[%0d] op=%0d got=%0d expected=%0d", it, op, start_idx, m_idx); end
        if (start_off !== exp_off(m_idx)) begin failures++; $display("FAIL rand_off[%0d] op=%0d got=%0d expected=%0d", it, op, start_off, exp_off(m_idx)); end
        if (start_cyc - pc !== 2) begin failures++; $display("FAIL rand_latency[%0d] got=%0d expected=2", it, start_cyc - pc); end
      end
    end
  endtask

  initial begin
    bus.auto_en     = 1'b0;
    bus.next_req    = 1'b0;
    bus.prev_req    = 1'b0;
    bus.refresh_req = 1'b0;
    test_reset();
    test_auto();
    test_prev_next();
    test_conflict();
    test_back_to_back();
    test_no_busy();
    test_random();
    test_rst_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ledmtx_sched.md
# ledmtx_sched

Frame scheduler for the MAX7219 LED-matrix driver (`ledmtx`). It decides which stored image is shown and when, and issues `start`/`ram_offset` to the driver only when the driver is idle. Requests come from three sources: an auto-advance dwell timer, manual next/prev pulses (board buttons, debounced upstream) and a refresh request. It replaces the free-running counter and offset logic in the board top level.

## Interface
- `NUM_IMAGES`, 7: images stored in driver RAM; must be ≥2.
- `IMG_STRIDE`, 13: RAM words per image; offset of image i = i*IMG_STRIDE.
- `DWELL_MAX`, 199_999_999: auto-advance terminal count; the timer counts 0..DWELL_MAX.
- `OFFSET_W`, 16: width of `drv_ram_offset`; (NUM_IMAGES-1)*IMG_STRIDE must fit, else elaboration error.
- `BUSY_TO`, 4: cycles to wait for `drv_busy` to rise after start.

- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `auto_en` in 1: enable dwell timer / auto-advance.
- `next_req` in 1: one-cycle pulse, step forward one image.
- `prev_req` in 1: one-cycle pulse, step back one image.
- `refresh_req` in 1: one-cycle pulse, resend current image.
- `drv_busy` in 1: driver busy flag.
- `drv_start` out 1: one-cycle start pulse to driver.
- `drv_ram_offset` out OFFSET_W: image base address to driver.
- `img_idx` out max(1,$clog2(NUM_IMAGES)): index of current image.
- `pending` out 1: OR of all pending request flags.

## Operation
- Reset values (rst=0): state IDLE, `img_idx`=0, `drv_ram_offset`=0, `drv_start`=0, dwell counter 0, pend_next/pend_prev/pend_auto=0. pend_refresh=1, so image 0 is sent immediately after reset. `pending`=1.
- Pending flags are set on the request pulse in any state. Each flag is single-depth: repeated pulses before service collapse into one request.
- Dwell counter: held at 0 while `auto_en`=0. When `auto_en`=1 it increments each cycle. At count == DWELL_MAX it wraps to 0 and sets pend_auto. It also clears to 0 when a manual step is accepted.
- The arbiter runs in IDLE only, on a cycle with `drv_busy`=0 and any flag set. Priority:
  1. pend_next and pend_prev both set: both cleared, treated as refresh, index unchanged.
  2. pend_next: idx+1; offset+IMG_STRIDE; wraps from NUM_IMAGES-1 to idx 0 / offset 0.
  3. pend_prev: idx-1; offset-IMG_STRIDE; wraps from 0 to NUM_IMAGES-1 / (NUM_IMAGES-1)*IMG_STRIDE.
  4. pend_auto: same as next.
  5. pend_refresh: no index change.
- The accepted manual step clears pend_auto and pend_refresh as well, since the new frame is sent anyway. Auto acceptance clears pend_refresh.
- Offset is maintained incrementally by add/subtract with wrap; no multiplier.
- States:
  - IDLE: arbitrate as above. On a grant, update idx/offset and go to ISSUE.
  - ISSUE: `drv_start`=1 for exactly this cycle; go to WAIT_BUSY.
  - WAIT_BUSY: go to WAIT_DONE when `drv_busy`=1. If BUSY_TO cycles pass without it, return to IDLE (frame treated as done).
  - WAIT_DONE: return to IDLE when `drv_busy`=0.
- `drv_ram_offset` and `img_idx` change only on the IDLE→ISSUE edge. They are stable from the ISSUE cycle until the next grant.

## Timing
- A request pulse in cycle c0 sets its flag in c1. If IDLE and not busy, the grant happens at the end of c1 and `drv_start`=1 in c2, with the new offset already valid in c2.
- Minimum spacing between successive `drv_start` pulses: ISSUE + 1 WAIT_BUSY + driver busy time + 1 cycle.
- `drv_busy`=1 while in IDLE (driver not yet released) blocks the grant. Flags stay held.
- Requests arriving in the same cycle as the grant that clears them are kept: the set takes priority over the clear.
- `rst` low mid-frame: all state returns to reset values on that edge. `drv_start` is low the next cycle; the driver shares `rst`.

## Test plan
- Reset release, NUM_IMAGES=7, IMG_STRIDE=13, driver model busy 20 cycles → `drv_start` in 2nd cycle after release, offset 0, `img_idx`=0, `pending`=0 after grant.
- `auto_en`=1, DWELL_MAX=99 → starts every ~100 cycles. Offsets run 13,26,…,78,0, and 78→0 wraps with idx 6→0.
- From idx 0, `prev_req` → offset 78, idx 6. Then `next_req` → offset 0, idx 0.
- `next_req` and `prev_req` in the same cycle at idx 3 → one start, offset 39, idx 3.
- Three `next_req` pulses during driver busy → exactly one start after busy falls, idx +1. Dwell counter restarts at 0.
- Driver model never raises busy → return to IDLE after BUSY_TO=4 cycles, and the next request is still served. `rst` low during WAIT_DONE → outputs return to reset values next cycle.
